// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX hazard sources in, pipeline stall/flush controls and status out.
// The pipeline side drives through master; hazard_ctrl consumes through slave.
interface hazard_ctrl_if #(
  parameter int CNT_WIDTH = 16
);
  logic [4:0]           id_rs1;
  logic [4:0]           id_rs2;
  logic                 id_use_rs1;
  logic                 id_use_rs2;
  logic                 ex_memread;
  logic [4:0]           ex_rd;
  logic                 ex_redirect;

  logic                 pc_stall;
  logic                 ifid_stall;
  logic                 ifid_flush;
  logic                 idex_stall;
  logic                 idex_flush;
  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] stall_count;
  logic [CNT_WIDTH-1:0] flush_count;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memread, ex_rd, ex_redirect,
    input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
    input  state, stall_count, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memread, ex_rd, ex_redirect,
    output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
    output state, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use stall and EX-redirect flush controller with a RUN/LU_STALL/FLUSH FSM and
// saturating stall-cycle / redirect-event counters. Controls respond in the same cycle.
module hazard_ctrl #(
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_WIDTH    = 16
) (
  input logic          clk,
  input logic          rstn,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam int MAX_HOLD  = (LOAD_LAT > FLUSH_CYCLES) ? LOAD_LAT : FLUSH_CYCLES;
  localparam int CW        = $clog2(MAX_HOLD + 1);
  localparam int LU_LOAD   = (LOAD_LAT > 1) ? LOAD_LAT - 2 : 0;
  localparam int FL_LOAD   = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0;
  localparam logic [CW-1:0] LU_RELOAD = CW'(LU_LOAD);
  localparam logic [CW-1:0] FL_RELOAD = CW'(FL_LOAD);

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [CNT_WIDTH-1:0] stall_count_q;
  logic [CNT_WIDTH-1:0] flush_count_q;

  logic load_use;
  logic flush_on;
  logic stall_on;

  assign load_use = hz.ex_memread && (hz.ex_rd != 5'd0) &&
                    ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                     (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

  // A redirect wins in every state, and flushing masks any stall request.
  assign flush_on = hz.ex_redirect || (state_q == FLUSH);
  assign stall_on = !flush_on && ((state_q == LU_STALL) || load_use);

  assign hz.pc_stall    = stall_on;
  assign hz.ifid_stall  = stall_on;
  assign hz.idex_stall  = stall_on;
  assign hz.ifid_flush  = flush_on;
  assign hz.idex_flush  = flush_on;
  assign hz.state       = state_q;
  assign hz.stall_count = stall_count_q;
  assign hz.flush_count = flush_count_q;

  // NOTE: non-blocking assignments keep every register sampling pre-edge values, so the
  // order of statements below does not change the hardware.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      if (stall_on && (stall_count_q != '1)) stall_count_q <= stall_count_q + 1'b1;

      if (hz.ex_redirect) begin
        if (flush_count_q != '1) flush_count_q <= flush_count_q + 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_q <= FLUSH;
          cnt_q   <= FL_RELOAD;
        end else begin
          state_q <= RUN;
          cnt_q   <= '0;
        end
      end else begin
        unique case (state_q)
          RUN: begin
            if (load_use && (LOAD_LAT > 1)) begin
              state_q <= LU_STALL;
              cnt_q   <= LU_RELOAD;
            end
          end
          LU_STALL, FLUSH: begin
            if (cnt_q == '0) state_q <= RUN;
            else             cnt_q   <= cnt_q - 1'b1;
          end
          default: state_q <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two parameterisations, a stimulus process pushing expected
// per-cycle responses and a monitor popping and comparing them at the falling edge.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_WIDTH(16)) if_a ();
  hazard_ctrl_if #(.CNT_WIDTH(2))  if_b ();

  hazard_ctrl #(.LOAD_LAT(1), .FLUSH_CYCLES(1), .CNT_WIDTH(16)) dut_a (
    .clk (clk),
    .rstn(rstn),
    .hz  (if_a.slave)
  );

  hazard_ctrl #(.LOAD_LAT(3), .FLUSH_CYCLES(2), .CNT_WIDTH(2)) dut_b (
    .clk (clk),
    .rstn(rstn),
    .hz  (if_b.slave)
  );

  // Control vector order: {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush}
  localparam logic [4:0] IDLE = 5'b00000;
  localparam logic [4:0] STL  = 5'b11010;
  localparam logic [4:0] FLS  = 5'b00101;

  typedef struct {
    bit          sel;
    logic [4:0]  ctl;
    logic [31:0] st;
    logic [31:0] sc;
    logic [31:0] fc;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every falling edge with a pending expectation compares the selected DUT.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [4:0]  ctl;
      logic [31:0] st, sc, fc;
      e = exp_q.pop_front();
      if (e.sel) begin
        ctl = {if_b.pc_stall, if_b.ifid_stall, if_b.ifid_flush, if_b.idex_stall, if_b.idex_flush};
        st  = 32'(if_b.state);
        sc  = 32'(if_b.stall_count);
        fc  = 32'(if_b.flush_count);
      end else begin
        ctl = {if_a.pc_stall, if_a.ifid_stall, if_a.ifid_flush, if_a.idex_stall, if_a.idex_flush};
        st  = 32'(if_a.state);
        sc  = 32'(if_a.stall_count);
        fc  = 32'(if_a.flush_count);
      end
      check({e.nm, ".ctl"},         32'(ctl), 32'(e.ctl));
      check({e.nm, ".state"},       st, e.st);
      check({e.nm, ".stall_count"}, sc, e.sc);
      check({e.nm, ".flush_count"}, fc, e.fc);
    end
  end

  task automatic drive(input bit sel, input logic [4:0] rs1, input logic [4:0] rs2,
                       input bit u1, input bit u2, input bit mr, input logic [4:0] rd,
                       input bit rdr);
    if (sel) begin
      if_b.id_rs1 = rs1; if_b.id_rs2 = rs2; if_b.id_use_rs1 = u1; if_b.id_use_rs2 = u2;
      if_b.ex_memread = mr; if_b.ex_rd = rd; if_b.ex_redirect = rdr;
    end else begin
      if_a.id_rs1 = rs1; if_a.id_rs2 = rs2; if_a.id_use_rs1 = u1; if_a.id_use_rs2 = u2;
      if_a.ex_memread = mr; if_a.ex_rd = rd; if_a.ex_redirect = rdr;
    end
  endtask

  // One pipeline cycle: drive inputs just after the edge and queue the response expected
  // before the next edge (counters/state reflect updates from earlier edges only).
  task automatic step(input bit sel, input logic [4:0] rs1, input logic [4:0] rs2,
                      input bit u1, input bit u2, input bit mr, input logic [4:0] rd,
                      input bit rdr, input logic [4:0] ectl, input int est,
                      input int esc, input int efc, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    drive(sel, rs1, rs2, u1, u2, mr, rd, rdr);
    e.sel = sel; e.ctl = ectl; e.st = 32'(est); e.sc = 32'(esc); e.fc = 32'(efc); e.nm = nm;
    exp_q.push_back(e);
  endtask

  // Shorthands: idle, load-use on rs2 (x5), redirect only.
  task automatic idle(input bit sel, input logic [4:0] ectl, input int est, input int esc,
                      input int efc, input string nm);
    step(sel, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, ectl, est, esc, efc, nm);
  endtask

  task automatic lu(input bit sel, input logic [4:0] ectl, input int est, input int esc,
                    input int efc, input string nm);
    step(sel, 5'd0, 5'd5, 0, 1, 1, 5'd5, 0, ectl, est, esc, efc, nm);
  endtask

  task automatic redir(input bit sel, input logic [4:0] ectl, input int est, input int esc,
                       input int efc, input string nm);
    step(sel, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, ectl, est, esc, efc, nm);
  endtask

  initial begin
    drive(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0);
    drive(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // LOAD_LAT=1, FLUSH_CYCLES=1, CNT_WIDTH=16
    idle (0, IDLE, 0, 0, 0, "a_reset_idle");
    lu   (0, STL,  0, 0, 0, "a_lu_rs2");
    idle (0, IDLE, 0, 1, 0, "a_after_lu");
    step (0, 5'd0, 5'd5, 0, 1, 1, 5'd0, 0, IDLE, 0, 1, 0, "a_rd_zero");
    step (0, 5'd7, 5'd7, 0, 0, 1, 5'd7, 0, IDLE, 0, 1, 0, "a_no_use");
    step (0, 5'd7, 5'd0, 1, 0, 0, 5'd7, 0, IDLE, 0, 1, 0, "a_not_load");
    step (0, 5'd7, 5'd0, 1, 0, 1, 5'd7, 0, STL,  0, 1, 0, "a_lu_rs1");
    step (0, 5'd0, 5'd5, 0, 1, 1, 5'd5, 1, FLS,  0, 2, 0, "a_redir_and_lu");
    idle (0, IDLE, 0, 2, 1, "a_after_redir");

    // LOAD_LAT=3, FLUSH_CYCLES=2, CNT_WIDTH=2 (counters stick at 3)
    idle (1, IDLE, 0, 0, 0, "b_idle");
    lu   (1, STL,  0, 0, 0, "b_lu_c1");
    idle (1, STL,  1, 1, 0, "b_lu_c2");
    idle (1, STL,  1, 2, 0, "b_lu_c3");
    idle (1, IDLE, 0, 3, 0, "b_lu_done");
    redir(1, FLS,  0, 3, 0, "b_redir_c1");
    idle (1, FLS,  2, 3, 1, "b_redir_c2");
    idle (1, IDLE, 0, 3, 1, "b_redir_done");
    lu   (1, STL,  0, 3, 1, "b_lu2_c1");
    redir(1, FLS,  1, 3, 1, "b_redir_in_lu");
    lu   (1, FLS,  2, 3, 2, "b_lu_masked_in_flush");
    idle (1, IDLE, 0, 3, 2, "b_back_to_run");
    redir(1, FLS,  0, 3, 2, "b_redir3");
    redir(1, FLS,  2, 3, 3, "b_redir4");
    redir(1, FLS,  2, 3, 3, "b_redir5_sat");
    idle (1, FLS,  2, 3, 3, "b_flush_tail");
    idle (1, IDLE, 0, 3, 3, "b_run_sat");
    lu   (1, STL,  0, 3, 3, "b_lu3_c1");
    idle (1, STL,  1, 3, 3, "b_lu3_c2");

    // Asynchronous reset mid-LU_STALL, asserted between clock edges.
    idle (1, IDLE, 0, 0, 0, "b_async_reset");
    rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    idle (1, IDLE, 0, 0, 0, "b_after_reset");

    repeat (3) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
